// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates the single memory bus between fetch (IF) and load/store (DM)
// DM has priority; a saturating starvation counter forces an IF grant after STARVE_MAX DM grants.
module mem_port_arbiter #(
  parameter int N          = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic         if_gnt,
  output logic         if_done,
  output logic [N-1:0] if_rdata,
  input  logic         dm_req,
  input  logic         dm_we,
  input  logic [N-1:0] dm_addr,
  input  logic [N-1:0] dm_wdata,
  output logic         dm_gnt,
  output logic         dm_done,
  output logic [N-1:0] dm_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic         sel,
  output logic         busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   starve_cnt;
  logic            dm_win, if_win;

  assign busy = (state != IDLE);

  always_comb begin
    dm_win     = dm_req && (!if_req || (starve_cnt < STARVE_LIM));
    if_win     = if_req && !dm_win;
    state_next = state;
    dm_gnt     = 1'b0;
    if_gnt     = 1'b0;
    case (state)
      IDLE: begin
        // No grants while reset is asserted, even though the state reads IDLE.
        if (rst_n) begin
          if (dm_win) begin
            dm_gnt     = 1'b1;
            state_next = BUSY_DM;
          end else if (if_win) begin
            if_gnt     = 1'b1;
            state_next = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      sel        <= 1'b0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      starve_cnt <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (dm_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        sel       <= 1'b1;
        if (!if_req)                       starve_cnt <= '0;
        else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
      end else if (if_gnt) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        sel        <= 1'b0;
        starve_cnt <= '0;
      end else if (busy && mem_ready) begin
        mem_req <= 1'b0;
        if (state == BUSY_IF) begin
          if_done  <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          dm_done <= 1'b1;
          if (!mem_we) dm_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int N          = 32;
  localparam int STARVE_MAX = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         if_req, dm_req, dm_we, mem_ready;
  logic [N-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic         if_gnt, if_done, dm_gnt, dm_done, mem_req, mem_we, sel, busy;
  logic [N-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.N(N), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [4*N+7:0] outs;
    idle_inputs();
    rst_n = 0; if_req = 1; dm_req = 1; dm_addr = 32'h200;
    for (int c = 0; c < 2; c++) begin
      step();
      outs = {mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_done, dm_done, sel, busy, if_gnt, dm_gnt};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, outs);
      end
    end
    rst_n = 1;
    #1;
    checks++;
    if ({dm_gnt, if_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release_grant: got dm_gnt=%b if_gnt=%b expected dm_gnt=1 if_gnt=0", dm_gnt, if_gnt);
    end
    step();
    if_req = 0; dm_req = 0; mem_ready = 1;
    step();
    mem_ready = 0;
    step();
  endtask

  task automatic test_if_read();
    if_req = 1; if_addr = 32'h0000_0040;
    #1;
    checks++;
    if ({if_gnt, dm_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL if_read_gnt: got if_gnt=%b dm_gnt=%b expected 1 0", if_gnt, dm_gnt);
    end
    step();
    if_req = 0; mem_ready = 1; mem_rdata = 32'h0051_0093;
    checks++;
    if ({mem_req, mem_we, sel, busy, mem_addr} !== {4'b1001, 32'h40}) begin
      errors++;
      $display("FAIL if_read_bus: got req=%b we=%b sel=%b busy=%b addr=%h expected 1 0 0 1 00000040",
               mem_req, mem_we, sel, busy, mem_addr);
    end
    step();
    mem_ready = 0; mem_rdata = 32'h1234_5678;
    checks++;
    if ({if_done, mem_req, if_rdata} !== {2'b10, 32'h0051_0093}) begin
      errors++;
      $display("FAIL if_read_done: got done=%b req=%b rdata=%h expected 1 0 00510093", if_done, mem_req, if_rdata);
    end
  endtask

  task automatic test_dm_store();
    logic [N-1:0] prev_rdata;
    prev_rdata = dm_rdata;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({dm_gnt, if_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL dm_store_gnt: got dm_gnt=%b if_gnt=%b expected 1 0", dm_gnt, if_gnt);
    end
    step();
    dm_req = 0; dm_we = 0; dm_addr = 32'hFFFF_FFFF; dm_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3); mem_rdata = 32'hCAFE_0000 + k;
      checks++;
      if ({mem_req, mem_we, sel, mem_addr, mem_wdata, dm_done} !== {3'b111, 32'h100, 32'hDEAD_BEEF, 1'b0}) begin
        errors++;
        $display("FAIL dm_store_hold cycle %0d: got req=%b we=%b sel=%b addr=%h wdata=%h done=%b", k,
                 mem_req, mem_we, sel, mem_addr, mem_wdata, dm_done);
      end
      step();
    end
    mem_ready = 0;
    checks++;
    if ({dm_done, mem_req, dm_rdata} !== {2'b10, prev_rdata}) begin
      errors++;
      $display("FAIL dm_store_done: got done=%b req=%b rdata=%h expected 1 0 %h", dm_done, mem_req, dm_rdata, prev_rdata);
    end
    step();
    checks++;
    if (dm_done !== 1'b0) begin
      errors++;
      $display("FAIL dm_store_single_pulse: got dm_done=%b expected 0", dm_done);
    end
  endtask

  task automatic test_both_same_cycle();
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; if_req = 1; if_addr = 32'h80;
    #1;
    checks++;
    if ({dm_gnt, if_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL both_first_gnt: got dm_gnt=%b if_gnt=%b expected 1 0", dm_gnt, if_gnt);
    end
    step();
    dm_req = 0; mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    #1;
    checks++;
    if (if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL both_no_gnt_busy: got if_gnt=%b expected 0", if_gnt);
    end
    step();
    mem_ready = 0;
    #1;
    checks++;
    if ({dm_done, if_gnt, dm_rdata} !== {2'b11, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL both_if_in_done_cycle: got dm_done=%b if_gnt=%b dm_rdata=%h expected 1 1 0badf00d",
               dm_done, if_gnt, dm_rdata);
    end
    step();
    if_req = 0; mem_ready = 1;
    step();
    mem_ready = 0;
    step();
  endtask

  task automatic test_starvation();
    int starve = 0;
    int grants = 0;
    int exp_dm;
    if_req = 1; dm_req = 1; dm_we = 0; mem_ready = 1;
    for (int c = 0; c < 40 && grants < 12; c++) begin
      #1;
      if (if_gnt || dm_gnt) begin
        exp_dm = (starve < STARVE_MAX) ? 1 : 0;
        checks++;
        if ({dm_gnt, if_gnt} !== {exp_dm[0], ~exp_dm[0]}) begin
          errors++;
          $display("FAIL starve_order grant %0d: got dm_gnt=%b if_gnt=%b expected dm_gnt=%0d", grants, dm_gnt, if_gnt, exp_dm);
        end
        starve = exp_dm ? starve + 1 : 0;
        grants++;
      end
      step();
    end
    checks++;
    if (grants != 12) begin
      errors++;
      $display("FAIL starve_grant_count: got %0d expected 12", grants);
    end
    if_req = 0; dm_req = 0;
    step();
    mem_ready = 0;
    step();
  endtask

  task automatic test_reset_mid();
    dm_req = 1; dm_we = 0; dm_addr = 32'h440;
    step();
    dm_req = 0; mem_ready = 0;
    step();
    checks++;
    if ({busy, sel, mem_req} !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid_busy: got busy=%b sel=%b req=%b expected 1 1 1", busy, sel, mem_req);
    end
    rst_n = 0;
    step();
    rst_n = 1;
    checks++;
    if ({mem_req, dm_done, busy, sel} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_abort: got req=%b done=%b busy=%b sel=%b expected 0 0 0 0", mem_req, dm_done, busy, sel);
    end
    mem_ready = 1;
    step();
    mem_ready = 0;
    checks++;
    if ({dm_done, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_no_done: got done=%b req=%b expected 0 0", dm_done, mem_req);
    end
  endtask

  task automatic test_random(input int ncyc);
    // Reference: owner 0=none 1=IF 2=DM; bus contents as last granted transaction.
    int owner = 0, starve = 0;
    logic m_req = 0, m_we = 0, m_sel = 0, m_if_done = 0, m_dm_done = 0;
    logic [N-1:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
    logic exp_ig, exp_dg;
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if ({mem_req, mem_we, sel, busy, if_done, dm_done} !== {m_req, m_we, m_sel, owner != 0, m_if_done, m_dm_done}) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d: got req/we/sel/busy/ifd/dmd=%b%b%b%b%b%b expected %b%b%b%b%b%b", c,
                 mem_req, mem_we, sel, busy, if_done, dm_done, m_req, m_we, m_sel, owner != 0, m_if_done, m_dm_done);
      end
      checks++;
      if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== {m_addr, m_wdata, m_if_rdata, m_dm_rdata}) begin
        errors++;
        $display("FAIL rand_data cycle %0d: got %h %h %h %h expected %h %h %h %h", c,
                 mem_addr, mem_wdata, if_rdata, dm_rdata, m_addr, m_wdata, m_if_rdata, m_dm_rdata);
      end
      if (if_req && $urandom_range(9) == 0) if_req = 0;
      else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dm_req && $urandom_range(9) == 0) dm_req = 0;
      else if (!dm_req && $urandom_range(2) == 0) begin
        dm_req = 1; dm_we = $urandom_range(1); dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_ready = $urandom_range(1);
      mem_rdata = $urandom;
      #1;
      exp_dg = (owner == 0) && dm_req && (!if_req || starve < STARVE_MAX);
      exp_ig = (owner == 0) && if_req && !exp_dg;
      checks++;
      if ({if_gnt, dm_gnt} !== {exp_ig, exp_dg}) begin
        errors++;
        $display("FAIL rand_gnt cycle %0d: got if_gnt=%b dm_gnt=%b expected %b %b", c, if_gnt, dm_gnt, exp_ig, exp_dg);
      end
      m_if_done = 0; m_dm_done = 0;
      if (owner != 0) begin
        if (mem_ready) begin
          if (owner == 1) begin
            m_if_done = 1; m_if_rdata = mem_rdata;
          end else begin
            m_dm_done = 1;
            if (!m_we) m_dm_rdata = mem_rdata;
          end
          owner = 0; m_req = 0;
        end
      end else if (exp_dg) begin
        owner = 2; m_req = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_sel = 1;
        starve = if_req ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
      end else if (exp_ig) begin
        owner = 1; m_req = 1; m_we = 0; m_addr = if_addr; m_wdata = '0; m_sel = 0;
        starve = 0;
      end
      step();
      if (exp_dg) dm_req = 0;
      if (exp_ig) if_req = 0;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_store();
    test_both_same_cycle();
    test_starvation();
    test_reset_mid();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory bus between instruction fetch (IF port) and load/store (DM port).
- Grants one requester at a time and registers its payload onto the bus.
- Holds the grant until the memory acknowledges.
- Drives the select line of the downstream address/data mux_2x1 instances (0 = IF, 1 = DM).
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
- N, 32, address/data width of every bus port.
- STARVE_MAX, 4, max consecutive DM grants allowed while if_req is pending (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- if_req  input  1  fetch request; held with if_addr until if_gnt.
- if_addr  input  N  fetch address.
- if_gnt  output  1  fetch accepted this cycle (combinational, IDLE only).
- if_done  output  1  one-cycle pulse: fetch data valid.
- if_rdata  output  N  fetch data, registered, held until next fetch done.
- dm_req  input  1  data request; held with payload until dm_gnt.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  N  data address.
- dm_wdata  input  N  store data.
- dm_gnt  output  1  data accepted this cycle (combinational, IDLE only).
- dm_done  output  1  one-cycle pulse: data access complete.
- dm_rdata  output  N  load data, registered; updated only on loads.
- mem_req  output  1  bus request, registered.
- mem_we  output  1  bus write enable, registered.
- mem_addr  output  N  bus address, registered.
- mem_wdata  output  N  bus write data, registered.
- mem_rdata  input  N  bus read data, valid when mem_ready=1.
- mem_ready  input  1  bus acknowledge; sampled only while mem_req=1.
- sel  output  1  owner select for datapath muxes: 0 = IF, 1 = DM.
- busy  output  1  1 when state ≠ IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; starve_cnt=0.
  - All outputs 0: mem_*, if_rdata, dm_rdata, done pulses, sel, busy.
- States and transitions:
  - IDLE → BUSY_IF on IF win; IDLE → BUSY_DM on DM win.
  - BUSY_x → IDLE on mem_ready=1.
- IDLE arbitration, combinational in the same cycle:
  - DM wins if dm_req && (!if_req || starve_cnt < STARVE_MAX).
  - Otherwise IF wins if if_req.
  - Winner's gnt=1 for exactly that cycle; the loser's gnt=0.
  - gnt is never asserted outside IDLE.
- On the grant edge:
  - Capture the winner's payload into mem_addr/mem_we/mem_wdata. IF grants force mem_we=0 and mem_wdata=0.
  - mem_req ← 1; sel ← winner; enter BUSY_x.
- In BUSY_x:
  - mem_req and the payload are held stable until mem_ready=1. Wait states are unbounded.
  - On the mem_ready edge: mem_req ← 0; state ← IDLE; x_done ← 1 for one cycle.
  - Loads and fetches also capture mem_rdata into x_rdata on that edge.
- Latency with zero wait states: gnt at cycle 0, mem_req at cycle 1, mem_ready at cycle 1, done and rdata at cycle 2.
  - The done cycle is an IDLE cycle, so a new grant may be issued in that same cycle.
  - Back-to-back throughput is one transaction per 2 cycles.
- sel holds its last value in IDLE; changes only on a grant edge.
- starve_cnt, width clog2(STARVE_MAX+1):
  - On a DM grant with if_req=1: increment, saturating at STARVE_MAX.
  - On a DM grant with if_req=0: clear.
  - On an IF grant: clear.
- A request dropped before gnt is legal and ignored.
- mem_ready while mem_req=0 is ignored.
- Reset mid-transaction:
  - Aborts the transaction; no done pulse.
  - mem_req=0 from the edge after rst_n sampled low.

Test Plan:
- Hold rst_n=0 for 2 cycles with both reqs high → all outputs 0, no gnt, state IDLE; release → DM granted first cycle after.
- IF read, if_addr=0x0000_0040, mem_ready at cycle 1 with mem_rdata=0x0051_0093:
  - if_gnt at cycle 0; mem_req=1, mem_addr=0x40, mem_we=0, sel=0 at cycle 1.
  - if_done=1 with if_rdata=0x0051_0093 at cycle 2.
- DM store, addr=0x100, wdata=0xDEAD_BEEF, mem_ready delayed 3 cycles:
  - mem_req/payload stable for 4 cycles; sel=1.
  - dm_done pulses once; dm_rdata unchanged.
- Both requests in the same IDLE cycle → dm_gnt=1, if_gnt=0; if_req held; IF granted in the dm_done cycle.
- Both reqs continuously high, STARVE_MAX=4, zero-wait memory → grant order DM,DM,DM,DM,IF, repeating.
- Reset asserted during BUSY_DM with mem_ready=0 → mem_req=0 next edge, no dm_done, busy=0, sel=0.
